// File: rtl/hsync_de_generator.sv
// -----------------------------------------------------------------------------
// hsync_de_generator
//
// Purpose:
//   Horizontal timing generator for one video frame. A rising edge of the
//   (active-low) VSYNC pulse starts a frame. At that point the six timing
//   inputs are captured and checked. A valid frame then runs VBP blanking
//   lines followed by VACT active lines of HTOTAL clocks each. The block
//   produces a line sync (HSYNC), a data enable (DE) and the active-line
//   index (LINE_CNT).
//
// Ports:
//   REF_CLK     in   1   single clock, rising edge
//   nRESET      in   1   asynchronous active-low reset
//   VSYNC       in   1   active-low frame sync, frame starts on its rising edge
//   HTOTAL      in   CW  clocks per line
//   HSW         in   CW  HSYNC width in clocks
//   HBP         in   CW  horizontal back porch in clocks
//   HACT        in   CW  active pixels per line
//   VBP         in   CW  vertical back-porch lines
//   VACT        in   CW  active lines
//   HSYNC       out  1   active-low line sync (registered)
//   DE          out  1   active-high data enable (registered)
//   LINE_CNT    out  CW  active-line index, 0 outside active lines (registered)
//   FRAME_DONE  out  1   one-cycle pulse after a frame completes normally
//   CFG_ERR     out  1   sticky flag, set by a frame start with a bad config
//   RESYNC      out  1   one-cycle pulse when a frame start aborts a frame
//
// HSYNC, DE and LINE_CNT decode the counters and state one clock late.
// FRAME_DONE and RESYNC are timed to match. Each is captured as an event
// on the edge where the frame ends or restarts, then presented one clock
// later.
// -----------------------------------------------------------------------------
module hsync_de_generator #(
    parameter int CW = 16
) (
    input  logic          REF_CLK,
    input  logic          nRESET,
    input  logic          VSYNC,
    input  logic [CW-1:0] HTOTAL,
    input  logic [CW-1:0] HSW,
    input  logic [CW-1:0] HBP,
    input  logic [CW-1:0] HACT,
    input  logic [CW-1:0] VBP,
    input  logic [CW-1:0] VACT,
    output logic          HSYNC,
    output logic          DE,
    output logic [CW-1:0] LINE_CNT,
    output logic          FRAME_DONE,
    output logic          CFG_ERR,
    output logic          RESYNC
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_ZERO    = {CW{1'b0}};
    localparam logic [CW:0]   C_ONE_W1  = {{CW{1'b0}}, 1'b1};
    localparam logic [CW+1:0] C_TWO_W2  = {{CW{1'b0}}, 2'b10};

    // A config is rejected if the line is too short, the sync pulse is
    // empty, the active window overruns the line, or there are no active
    // lines. h_end is already widened, so the sum cannot wrap.
    function automatic logic cfg_invalid(
        input logic [CW-1:0] htotal,
        input logic [CW-1:0] hsw,
        input logic [CW-1:0] vact,
        input logic [CW+1:0] h_end
    );
        logic [CW+1:0] ht_x;
        ht_x = {2'b00, htotal};
        return (ht_x < C_TWO_W2) || (hsw == C_ZERO) ||
               (h_end > ht_x) || (vact == C_ZERO);
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;
    logic          r_vs_d;

    logic [CW-1:0] r_htotal;
    logic [CW-1:0] r_hsw;
    logic [CW-1:0] r_hbp;
    logic [CW-1:0] r_hact;
    logic [CW-1:0] r_vbp;
    logic [CW-1:0] r_vact;

    logic          r_hsync;
    logic          r_de;
    logic [CW-1:0] r_line_cnt;
    logic          r_done_evt;
    logic          r_frame_done;
    logic          r_resync_evt;
    logic          r_resync;
    logic          r_cfg_err;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic          w_frame_start;
    logic [CW+1:0] w_h_start_in;
    logic [CW+1:0] w_h_end_in;
    logic          w_cfg_bad;
    logic [CW+1:0] w_h_start;
    logic [CW+1:0] w_h_end;
    logic [CW:0]   w_hcnt_inc;
    logic [CW:0]   w_vcnt_inc;
    logic          w_eol;
    logic          w_vblank_last;
    logic          w_last_eol;

    state_t        w_state_nxt;
    logic [CW-1:0] w_hcnt_nxt;
    logic [CW-1:0] w_vcnt_nxt;
    logic          w_done_evt;
    logic          w_resync_evt;

    logic          w_hsync_nxt;
    logic          w_de_nxt;
    logic [CW-1:0] w_line_cnt_nxt;

    // Only a low-to-high VSYNC transition starts a frame. A level held
    // high or low never does.
    assign w_frame_start = VSYNC & ~r_vs_d;

    // The live inputs are checked at the frame start. The latched copies
    // drive the decode for the rest of the frame.
    assign w_h_start_in = {2'b00, HSW} + {2'b00, HBP};
    assign w_h_end_in   = w_h_start_in + {2'b00, HACT};
    assign w_cfg_bad    = cfg_invalid(HTOTAL, HSW, VACT, w_h_end_in);

    assign w_h_start = {2'b00, r_hsw} + {2'b00, r_hbp};
    assign w_h_end   = w_h_start + {2'b00, r_hact};

    // The increments are one bit wider, so HTOTAL-1 / VBP-1 / VACT-1 never
    // underflow when they are compared.
    assign w_hcnt_inc    = {1'b0, r_hcnt} + C_ONE_W1;
    assign w_vcnt_inc    = {1'b0, r_vcnt} + C_ONE_W1;
    assign w_eol         = (r_state != ST_IDLE) && (w_hcnt_inc == {1'b0, r_htotal});
    assign w_vblank_last = (r_state == ST_VBLANK) && w_eol && (w_vcnt_inc == {1'b0, r_vbp});
    assign w_last_eol    = (r_state == ST_ACTIVE) && w_eol && (w_vcnt_inc == {1'b0, r_vact});

    // Next state and counters. A frame start overrides normal sequencing.
    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_vcnt_nxt   = r_vcnt;
        w_done_evt   = 1'b0;
        w_resync_evt = 1'b0;

        if (w_frame_start) begin
            w_hcnt_nxt = C_ZERO;
            w_vcnt_nxt = C_ZERO;
            if (w_cfg_bad) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = (VBP != C_ZERO) ? ST_VBLANK : ST_ACTIVE;
                // A restart on the frame's own last edge counts as a
                // clean handover, not an abort.
                w_resync_evt = (r_state != ST_IDLE) && !w_last_eol;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_hcnt_nxt = C_ZERO;
                    w_vcnt_nxt = C_ZERO;
                end
                ST_VBLANK: begin
                    if (w_eol) begin
                        w_hcnt_nxt = C_ZERO;
                        if (w_vblank_last) begin
                            w_state_nxt = ST_ACTIVE;
                            w_vcnt_nxt  = C_ZERO;
                        end else begin
                            w_vcnt_nxt  = w_vcnt_inc[CW-1:0];
                        end
                    end else begin
                        w_hcnt_nxt = w_hcnt_inc[CW-1:0];
                    end
                end
                ST_ACTIVE: begin
                    if (w_eol) begin
                        w_hcnt_nxt = C_ZERO;
                        if (w_last_eol) begin
                            w_state_nxt = ST_IDLE;
                            w_vcnt_nxt  = C_ZERO;
                            w_done_evt  = 1'b1;
                        end else begin
                            w_vcnt_nxt  = w_vcnt_inc[CW-1:0];
                        end
                    end else begin
                        w_hcnt_nxt = w_hcnt_inc[CW-1:0];
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hcnt_nxt  = C_ZERO;
                    w_vcnt_nxt  = C_ZERO;
                end
            endcase
        end
    end

    // Output decode of the current state/counters, registered below.
    always_comb begin
        w_hsync_nxt    = 1'b1;
        w_de_nxt       = 1'b0;
        w_line_cnt_nxt = C_ZERO;
        if (r_state != ST_IDLE) begin
            w_hsync_nxt = !(r_hcnt < r_hsw);
        end else begin
            w_hsync_nxt = 1'b1;
        end
        if (r_state == ST_ACTIVE) begin
            w_de_nxt       = ({2'b00, r_hcnt} >= w_h_start) && ({2'b00, r_hcnt} < w_h_end);
            w_line_cnt_nxt = r_vcnt;
        end else begin
            w_de_nxt       = 1'b0;
            w_line_cnt_nxt = C_ZERO;
        end
    end

    // FSM state, counters and VSYNC history.
    always_ff @(posedge REF_CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= ST_IDLE;
            r_hcnt  <= C_ZERO;
            r_vcnt  <= C_ZERO;
            r_vs_d  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_vcnt  <= w_vcnt_nxt;
            r_vs_d  <= VSYNC;
        end
    end

    // Timing inputs are captured at each frame start and held for the frame.
    always_ff @(posedge REF_CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_htotal <= C_ZERO;
            r_hsw    <= C_ZERO;
            r_hbp    <= C_ZERO;
            r_hact   <= C_ZERO;
            r_vbp    <= C_ZERO;
            r_vact   <= C_ZERO;
        end else if (w_frame_start) begin
            r_htotal <= HTOTAL;
            r_hsw    <= HSW;
            r_hbp    <= HBP;
            r_hact   <= HACT;
            r_vbp    <= VBP;
            r_vact   <= VACT;
        end else begin
            r_htotal <= r_htotal;
            r_hsw    <= r_hsw;
            r_hbp    <= r_hbp;
            r_hact   <= r_hact;
            r_vbp    <= r_vbp;
            r_vact   <= r_vact;
        end
    end

    // Registered outputs. Events are staged one extra clock so they line
    // up with the one-clock lag of HSYNC/DE/LINE_CNT.
    always_ff @(posedge REF_CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_hsync      <= 1'b1;
            r_de         <= 1'b0;
            r_line_cnt   <= C_ZERO;
            r_done_evt   <= 1'b0;
            r_frame_done <= 1'b0;
            r_resync_evt <= 1'b0;
            r_resync     <= 1'b0;
        end else begin
            r_hsync      <= w_hsync_nxt;
            r_de         <= w_de_nxt;
            r_line_cnt   <= w_line_cnt_nxt;
            r_done_evt   <= w_done_evt;
            r_frame_done <= r_done_evt;
            r_resync_evt <= w_resync_evt;
            r_resync     <= r_resync_evt;
        end
    end

    // Sticky config error. Each frame start overwrites it with the
    // verdict on that frame's config.
    always_ff @(posedge REF_CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_cfg_err <= 1'b0;
        end else if (w_frame_start) begin
            r_cfg_err <= w_cfg_bad;
        end else begin
            r_cfg_err <= r_cfg_err;
        end
    end

    assign HSYNC      = r_hsync;
    assign DE         = r_de;
    assign LINE_CNT   = r_line_cnt;
    assign FRAME_DONE = r_frame_done;
    assign CFG_ERR    = r_cfg_err;
    assign RESYNC     = r_resync;

endmodule

// File: tb/tb_hsync_de_generator.sv
// -----------------------------------------------------------------------------
// tb_hsync_de_generator
//
// Directed bench for hsync_de_generator. A table of timing configurations
// is applied with one frame start each. Per-frame statistics (first and
// last DE offset, DE and HSYNC-low counts, FRAME_DONE/RESYNC counts and
// offsets) are compared against hand-computed values. Hand-written
// sequences follow for restart, coincident restart, mid-frame config
// change and asynchronous reset. Offsets are counted in rising edges from
// the edge E that sees the frame start.
// -----------------------------------------------------------------------------
module tb_hsync_de_generator;

    localparam int CW = 16;

    logic          REF_CLK = 1'b0;
    logic          nRESET;
    logic          VSYNC;
    logic [CW-1:0] HTOTAL, HSW, HBP, HACT, VBP, VACT;
    logic          HSYNC, DE, FRAME_DONE, CFG_ERR, RESYNC;
    logic [CW-1:0] LINE_CNT;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int s_first_de, s_last_de, s_lc_last, s_de_cnt, s_hs_cnt;
    int s_done_cnt, s_done_off, s_rs_cnt, s_rs_off;

    typedef struct {
        int ht; int hsw; int hbp; int hact; int vbp; int vact;
        int err; int fde; int lde; int lc; int de; int hs; int done;
    } vec_t;

    vec_t vecs [9];

    hsync_de_generator #(.CW(CW)) dut (
        .REF_CLK    (REF_CLK),
        .nRESET     (nRESET),
        .VSYNC      (VSYNC),
        .HTOTAL     (HTOTAL),
        .HSW        (HSW),
        .HBP        (HBP),
        .HACT       (HACT),
        .VBP        (VBP),
        .VACT       (VACT),
        .HSYNC      (HSYNC),
        .DE         (DE),
        .LINE_CNT   (LINE_CNT),
        .FRAME_DONE (FRAME_DONE),
        .CFG_ERR    (CFG_ERR),
        .RESYNC     (RESYNC)
    );

    always #5 REF_CLK = ~REF_CLK;

    always @(posedge REF_CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input int ht, input int hsw, input int hbp,
                           input int hact, input int vbp, input int vact);
        HTOTAL = CW'(ht);
        HSW    = CW'(hsw);
        HBP    = CW'(hbp);
        HACT   = CW'(hact);
        VBP    = CW'(vbp);
        VACT   = CW'(vact);
    endtask

    // Drops VSYNC for one edge and raises it for the next. The edge that
    // sees the rise is returned as e.
    task automatic start_frame(output int e);
        @(negedge REF_CLK);
        VSYNC = 1'b0;
        @(negedge REF_CLK);
        VSYNC = 1'b1;
        e = cyc + 1;
    endtask

    // Samples n falling edges and collects statistics relative to edge e.
    // rs>0 schedules a second frame start at edge e+rs. chg>0 drives
    // HTOTAL to chg_val at offset chg.
    task automatic observe(input int e, input int n, input int rs,
                           input int chg, input logic [CW-1:0] chg_val);
        int off;
        s_first_de = -1; s_last_de = -1; s_lc_last = 0; s_de_cnt = 0;
        s_hs_cnt = 0; s_done_cnt = 0; s_done_off = -1; s_rs_cnt = 0; s_rs_off = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge REF_CLK);
            off = cyc - e;
            if (rs > 0 && off == rs - 2) VSYNC = 1'b0;
            if (rs > 0 && off == rs - 1) VSYNC = 1'b1;
            if (chg > 0 && off == chg) HTOTAL = chg_val;
            if (DE) begin
                if (s_first_de < 0) s_first_de = off;
                s_last_de = off;
                s_lc_last = int'(LINE_CNT);
                s_de_cnt  = s_de_cnt + 1;
            end
            if (!HSYNC) s_hs_cnt = s_hs_cnt + 1;
            if (FRAME_DONE) begin
                s_done_cnt = s_done_cnt + 1;
                s_done_off = off;
            end
            if (RESYNC) begin
                s_rs_cnt = s_rs_cnt + 1;
                if (s_rs_off < 0) s_rs_off = off;
            end
        end
    endtask

    initial begin
        int e;

        //            ht hsw hbp hact vbp vact | err fde lde lc de hs done
        vecs[0] = '{10, 2, 1, 5, 2, 3,   0, 24, 48, 2, 15, 10, 51};
        vecs[1] = '{10, 2, 1, 8, 2, 3,   1, -1, -1, 0,  0,  0, -1};
        vecs[2] = '{10, 2, 1, 5, 0, 3,   0,  4, 28, 2, 15,  6, 31};
        vecs[3] = '{ 1, 1, 0, 0, 0, 1,   1, -1, -1, 0,  0,  0, -1};
        vecs[4] = '{ 8, 1, 2, 5, 1, 2,   0, 12, 24, 1, 10,  3, 25};
        vecs[5] = '{10, 0, 1, 5, 0, 3,   1, -1, -1, 0,  0,  0, -1};
        vecs[6] = '{ 2, 1, 0, 1, 0, 1,   0,  2,  2, 0,  1,  1,  3};
        vecs[7] = '{10, 2, 1, 5, 0, 0,   1, -1, -1, 0,  0,  0, -1};
        vecs[8] = '{10, 3, 2, 5, 1, 1,   0, 16, 20, 0,  5,  6, 21};

        nRESET = 1'b1;
        VSYNC  = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0);
        #1 nRESET = 1'b0;
        #2;
        chk("rst hsync",      int'(HSYNC),      1);
        chk("rst de",         int'(DE),         0);
        chk("rst line_cnt",   int'(LINE_CNT),   0);
        chk("rst frame_done", int'(FRAME_DONE), 0);
        chk("rst cfg_err",    int'(CFG_ERR),    0);
        chk("rst resync",     int'(RESYNC),     0);
        repeat (3) @(negedge REF_CLK);
        nRESET = 1'b1;

        // Table-driven single frames.
        for (int i = 0; i < 9; i++) begin
            set_cfg(vecs[i].ht, vecs[i].hsw, vecs[i].hbp, vecs[i].hact, vecs[i].vbp, vecs[i].vact);
            start_frame(e);
            observe(e, 70, 0, 0, '0);
            chk($sformatf("v%0d cfg_err", i),    int'(CFG_ERR), vecs[i].err);
            chk($sformatf("v%0d first_de", i),   s_first_de,    vecs[i].fde);
            chk($sformatf("v%0d last_de", i),    s_last_de,     vecs[i].lde);
            chk($sformatf("v%0d line_cnt", i),   s_lc_last,     vecs[i].lc);
            chk($sformatf("v%0d de_cnt", i),     s_de_cnt,      vecs[i].de);
            chk($sformatf("v%0d hsync_lo", i),   s_hs_cnt,      vecs[i].hs);
            chk($sformatf("v%0d done_off", i),   s_done_off,    vecs[i].done);
            chk($sformatf("v%0d done_cnt", i),   s_done_cnt,    (vecs[i].done >= 0) ? 1 : 0);
            chk($sformatf("v%0d resync_cnt", i), s_rs_cnt,      0);
        end

        // Restart 15 clocks into a frame.
        set_cfg(10, 2, 1, 5, 2, 3);
        start_frame(e);
        observe(e, 100, 15, 0, '0);
        chk("rs resync_cnt", s_rs_cnt,   1);
        chk("rs resync_off", s_rs_off,   16);
        chk("rs done_cnt",   s_done_cnt, 1);
        chk("rs done_off",   s_done_off, 66);
        chk("rs first_de",   s_first_de, 39);
        chk("rs de_cnt",     s_de_cnt,   15);
        chk("rs hsync_lo",   s_hs_cnt,   14);

        // Restart on the final end-of-line edge.
        set_cfg(10, 2, 1, 5, 0, 3);
        start_frame(e);
        observe(e, 80, 30, 0, '0);
        chk("eol resync_cnt", s_rs_cnt,   0);
        chk("eol done_cnt",   s_done_cnt, 1);
        chk("eol done_off",   s_done_off, 61);
        chk("eol de_cnt",     s_de_cnt,   30);

        // HTOTAL changed mid-frame, then used by the next frame.
        set_cfg(10, 2, 1, 5, 2, 3);
        start_frame(e);
        observe(e, 70, 0, 5, 16'd20);
        chk("chg1 done_off", s_done_off, 51);
        chk("chg1 last_de",  s_last_de,  48);
        chk("chg1 de_cnt",   s_de_cnt,   15);
        start_frame(e);
        observe(e, 120, 0, 0, '0);
        chk("chg2 first_de", s_first_de, 44);
        chk("chg2 last_de",  s_last_de,  88);
        chk("chg2 done_off", s_done_off, 101);
        chk("chg2 hsync_lo", s_hs_cnt,   10);

        // Asynchronous reset during an active line.
        set_cfg(10, 2, 1, 5, 2, 3);
        start_frame(e);
        for (int i = 0; i < 40 && (cyc - e) < 35; i++) @(negedge REF_CLK);
        chk("prerst de",       int'(DE),       1);
        chk("prerst line_cnt", int'(LINE_CNT), 1);
        #2 nRESET = 1'b0;
        #1;
        chk("arst de",         int'(DE),         0);
        chk("arst hsync",      int'(HSYNC),      1);
        chk("arst line_cnt",   int'(LINE_CNT),   0);
        chk("arst frame_done", int'(FRAME_DONE), 0);
        chk("arst resync",     int'(RESYNC),     0);
        @(negedge REF_CLK);
        @(negedge REF_CLK);
        nRESET = 1'b1;
        observe(cyc + 1, 60, 0, 0, '0);
        chk("post_rst hsync_lo", s_hs_cnt,   0);
        chk("post_rst de_cnt",   s_de_cnt,   0);
        chk("post_rst done_cnt", s_done_cnt, 0);
        VSYNC = 1'b0;
        observe(cyc + 1, 30, 0, 0, '0);
        chk("vs_low hsync_lo", s_hs_cnt, 0);
        chk("vs_low de_cnt",   s_de_cnt, 0);
        start_frame(e);
        observe(e, 70, 0, 0, '0);
        chk("after_rst first_de", s_first_de, 24);
        chk("after_rst done_off", s_done_off, 51);
        chk("after_rst de_cnt",   s_de_cnt,   15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hsync_de_generator.md
HSYNC_DE_GENERATOR -- requirements
Module: hsync_de_generator

Interface
REQ-001 SHALL have parameter CW, default 16, width in bits of all horizontal and vertical timing inputs and counters.
REQ-002 SHALL have port REF_CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRESET, input, 1: reset is asynchronous and active-low.
REQ-004 SHALL have port VSYNC, input, 1, frame sync from the upstream vertical-sync stage; active-low pulse, same clock domain.
REQ-005 SHALL have ports HTOTAL, HSW, HBP, HACT, input, CW each: clocks per line, HSYNC width, horizontal back porch, active pixels.
REQ-006 SHALL have ports VBP, VACT, input, CW each: back-porch lines, active lines.
REQ-007 SHALL have port HSYNC, output, 1, active-low line sync.
REQ-008 SHALL have port DE, output, 1, active-high data enable.
REQ-009 SHALL have port LINE_CNT, output, CW, active-line index.
REQ-010 SHALL have port FRAME_DONE, output, 1, single-cycle end-of-frame pulse.
REQ-011 SHALL have port CFG_ERR, output, 1, sticky configuration-error flag.
REQ-012 SHALL have port RESYNC, output, 1, single-cycle pulse when a frame start interrupts a running frame.

Function
REQ-013 SHALL register VSYNC each clock into VS_D; a frame start occurs at any edge where VSYNC=1 and VS_D=0.
REQ-014 SHALL latch all six timing inputs at each frame start; input changes mid-frame SHALL have no effect until the next frame start.
REQ-015 SHALL use an FSM with states IDLE, VBLANK, ACTIVE.
REQ-016 SHALL compute H_START=HSW+HBP and H_END=H_START+HACT in CW+2 bits, with no truncation.
REQ-017 Config is invalid if HTOTAL<2, HSW=0, H_END>HTOTAL, or VACT=0.
REQ-018 On a frame start with invalid config, SHALL go or stay in IDLE and set CFG_ERR=1.
REQ-019 CFG_ERR SHALL stay 1 until a frame start with valid config, which clears it.
REQ-020 On a frame start with valid config, SHALL set HCNT=0 and VCNT=0, and enter VBLANK if VBP>0, else ACTIVE.
REQ-021 HCNT SHALL increment each clock outside IDLE; at HCNT=HTOTAL-1 it SHALL wrap to 0 (end of line) and VCNT SHALL increment.
REQ-022 At end of line in VBLANK with VCNT=VBP-1, SHALL enter ACTIVE with VCNT=0.
REQ-023 At end of line in ACTIVE with VCNT=VACT-1, SHALL enter IDLE and assert FRAME_DONE for exactly the next cycle.
REQ-024 HSYNC, DE and LINE_CNT SHALL be registered and lag the HCNT/VCNT/state they decode by exactly one clock.
REQ-025 HSYNC SHALL be 0 iff state is not IDLE and HCNT<HSW.
REQ-026 DE SHALL be 1 iff state is ACTIVE and H_START<=HCNT<H_END.
REQ-027 LINE_CNT SHALL equal VCNT in ACTIVE and 0 otherwise.
REQ-028 In IDLE: HSYNC=1, DE=0, counters held at 0.
REQ-029 A frame start in VBLANK or ACTIVE SHALL restart per REQ-020 and pulse RESYNC the next cycle; FRAME_DONE SHALL NOT pulse for the aborted frame.
REQ-030 If a frame start coincides with the final end of line, the restart SHALL win: no FRAME_DONE, no RESYNC.
REQ-031 A VSYNC held high or held low SHALL never produce a frame start.

Reset
REQ-032 nRESET=0 SHALL immediately set state=IDLE, HCNT=VCNT=0, VS_D=1, HSYNC=1, DE=0, LINE_CNT=0, FRAME_DONE=0, CFG_ERR=0, RESYNC=0, regardless of clock.
REQ-033 Reset asserted mid-frame SHALL abort the frame; after release, no output activity until a new frame start.

Verification
REQ-034 Config HTOTAL=10, HSW=2, HBP=1, HACT=5, VBP=2, VACT=3 plus one frame start at edge E: 50 clocks of activity; HSYNC low 2 clocks per line starting E+1; DE high 5 clocks per line on lines 3-5 only, first DE at E+24; FRAME_DONE at E+51.
REQ-035 Same config with VBP=0: DE first high at E+4; FRAME_DONE at E+31.
REQ-036 HACT=8 (H_END=11>HTOTAL=10) with frame start: CFG_ERR=1, HSYNC stays 1, DE stays 0; next start with HACT=5 clears CFG_ERR and runs normally.
REQ-037 Second frame start issued 15 clocks after the first: RESYNC pulse once, counters restart, no FRAME_DONE for the first frame, full 50-clock frame follows.
REQ-038 nRESET pulsed low during the ACTIVE state: outputs reach reset values without a clock edge, and stay idle until the next VSYNC rising edge.
REQ-039 HTOTAL changed mid-frame from 10 to 20: current frame keeps 10-clock lines; next frame uses 20.
